wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between two sources: the in-order pipeline write-back (ResultW/RdW) and a long-latency unit (multicycle MUL/DIV, cache-miss load).
- The pipeline always has priority. Long-latency results wait in a small FIFO and drain into idle write-port slots.
- A pending-register scoreboard tells the hazard unit which destinations are still outstanding.
- A starvation guard requests a pipeline bubble when a buffered result has waited too long.

---
 rtl/wb_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: pipeline results take the register-file port first, long-latency results queue and drain into idle slots.
// Optional WBARB_BYPASS_EN lets a long result go straight to the port when the queue is empty and the pipeline is idle.
module wb_port_arbiter #(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        RegWriteW,
    input  logic [4:0]  RdW,
    input  logic [31:0] ResultW,
    input  logic        LongValid,
    output logic        LongReady,
    input  logic [4:0]  LongRd,
    input  logic [31:0] LongData,
    input  logic        IssueLong,
    input  logic [4:0]  IssueRd,
    output logic        RfWE,
    output logic [4:0]  RfRd,
    output logic [31:0] RfWD,
    output logic [31:0] PendingMask,
    output logic        StallReq
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(STARVE_LIMIT);

    logic [4:0]       rdMem   [DEPTH];
    logic [31:0]      dataMem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] count;
    logic [AGE_W-1:0] age;
    logic [AGE_W-1:0] ageNext;
    logic [31:0]      pendMask;
    logic [31:0]      maskNext;

    logic        pipeWr;
    logic        fifoEmpty;
    logic        fifoFull;
    logic        bypass;
    logic        pushEn;
    logic        popEn;
    logic [4:0]  headRd;
    logic [31:0] headData;

    assign pipeWr    = RegWriteW && (RdW != '0);
    assign fifoEmpty = (count == '0);
    assign fifoFull  = (count == FULL_CNT);
    assign headRd    = rdMem[rdPtr];
    assign headData  = dataMem[rdPtr];

`ifdef WBARB_BYPASS_EN
    assign bypass = fifoEmpty && !pipeWr && LongValid && (LongRd != '0);
`else
    assign bypass = 1'b0;
`endif

    // Ready depends on occupancy alone, so a full queue never accepts even while popping.
    assign LongReady = !fifoFull;
    // Writes to x0 are accepted from the long unit but never occupy a slot.
    assign pushEn    = LongValid && !fifoFull && (LongRd != '0) && !bypass;
    assign popEn     = !pipeWr && !fifoEmpty;

    always_comb begin
        RfWE = 1'b0;
        RfRd = '0;
        RfWD = '0;
        if (RESET) begin
            if (pipeWr) begin
                RfWE = 1'b1;
                RfRd = RdW;
                RfWD = ResultW;
            end else if (!fifoEmpty) begin
                RfWE = 1'b1;
                RfRd = headRd;
                RfWD = headData;
            end else if (bypass) begin
                RfWE = 1'b1;
                RfRd = LongRd;
                RfWD = LongData;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (pushEn) begin
            rdMem[wrPtr]   <= LongRd;
            dataMem[wrPtr] <= LongData;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushEn) wrPtr <= wrPtr + PTR_W'(1);
            if (popEn)  rdPtr <= rdPtr + PTR_W'(1);
            unique case ({pushEn, popEn})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Clears are applied before sets so a fresh issue to the same register stays pending.
    always_comb begin
        maskNext = pendMask;
        if (popEn)  maskNext[headRd] = 1'b0;
        if (bypass) maskNext[LongRd] = 1'b0;
        if (IssueLong && (IssueRd != '0)) maskNext[IssueRd] = 1'b1;
        maskNext[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) pendMask <= '0;
        else        pendMask <= maskNext;
    end

    assign PendingMask = pendMask;

    always_comb begin
        ageNext = age;
        if (fifoEmpty || popEn)
            ageNext = '0;
        else if (pipeWr && (age != AGE_MAX))
            ageNext = age + AGE_W'(1);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) age <= '0;
        else        age <= ageNext;
    end

    assign StallReq = (age == AGE_MAX);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: vector table for port ownership, scoreboard of long results, hand sequences for corner cases.
// Expectations follow WBARB_BYPASS_EN when it is defined for the build.
module tb_wb_port_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic        LongValid;
    logic        LongReady;
    logic [4:0]  LongRd;
    logic [31:0] LongData;
    logic        IssueLong;
    logic [4:0]  IssueRd;
    logic        RfWE;
    logic [4:0]  RfRd;
    logic [31:0] RfWD;
    logic [31:0] PendingMask;
    logic        StallReq;

    int unsigned passCnt  = 0;
    int unsigned totalCnt = 0;
    logic        monEn    = 1'b0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } sb_t;
    sb_t sbQ[$];

    typedef struct {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldata;
        logic        we;
        logic [4:0]  erd;
        logic [31:0] ewd;
        logic        ready;
    } vec_t;
    vec_t vecs[10];

    always #5 CLK = ~CLK;

    wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(8)) dut (
        .CLK(CLK), .RESET(RESET),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .LongValid(LongValid), .LongReady(LongReady), .LongRd(LongRd), .LongData(LongData),
        .IssueLong(IssueLong), .IssueRd(IssueRd),
        .RfWE(RfWE), .RfRd(RfRd), .RfWD(RfWD),
        .PendingMask(PendingMask), .StallReq(StallReq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        RegWriteW = 1'b0; RdW = '0; ResultW = '0;
        LongValid = 1'b0; LongRd = '0; LongData = '0;
        IssueLong = 1'b0; IssueRd = '0;
    endtask

    // Scoreboard monitor: the queue models FIFO contents; pops are compared against RF writes in idle pipeline slots.
    always @(negedge CLK) begin
        if (RESET && monEn) begin
            logic pipe, modelReady, expBypass;
            sb_t e;
            pipe       = RegWriteW && (RdW != 5'd0);
            modelReady = (sbQ.size() < 2);
            expBypass  = 1'b0;
`ifdef WBARB_BYPASS_EN
            expBypass = (sbQ.size() == 0) && !pipe && LongValid && (LongRd != 5'd0);
`endif
            check("sb_ready", {31'd0, LongReady}, {31'd0, modelReady});
            if (!pipe) begin
                if (expBypass) begin
                    check("sb_bypass_we", {31'd0, RfWE}, 32'd1);
                    check("sb_bypass_rd", {27'd0, RfRd}, {27'd0, LongRd});
                    check("sb_bypass_wd", RfWD, LongData);
                end else if (sbQ.size() > 0) begin
                    e = sbQ.pop_front();
                    check("sb_pop_we", {31'd0, RfWE}, 32'd1);
                    check("sb_pop_rd", {27'd0, RfRd}, {27'd0, e.rd});
                    check("sb_pop_wd", RfWD, e.data);
                end else begin
                    check("sb_no_write", {31'd0, RfWE}, 32'd0);
                end
            end
            if (LongValid && modelReady && (LongRd != 5'd0) && !expBypass) begin
                e.rd = LongRd; e.data = LongData;
                sbQ.push_back(e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //        rw  rd   res            lv  lrd  ldata          we  erd  ewd            ready
        vecs[0] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 32'h0,         1'b1};
        vecs[1] = '{1'b1, 5'd0, 32'hFFFF0000,  1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 32'h0,         1'b1};
        vecs[2] = '{1'b1, 5'd5, 32'hAAAA0001,  1'b1, 5'd7,  32'h00001234,  1'b1, 5'd5, 32'hAAAA0001,  1'b1};
        vecs[3] = '{1'b1, 5'd6, 32'hBBBB0002,  1'b1, 5'd0,  32'hDEADBEEF,  1'b1, 5'd6, 32'hBBBB0002,  1'b1};
        vecs[4] = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd8,  32'h00000088,  1'b1, 5'd7, 32'h00001234,  1'b1};
        vecs[5] = '{1'b1, 5'd3, 32'hCCCC0003,  1'b1, 5'd9,  32'h00000099,  1'b1, 5'd3, 32'hCCCC0003,  1'b1};
        vecs[6] = '{1'b1, 5'd4, 32'hDDDD0004,  1'b1, 5'd10, 32'h000000AA,  1'b1, 5'd4, 32'hDDDD0004,  1'b0};
        vecs[7] = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd10, 32'h000000AA,  1'b1, 5'd8, 32'h00000088,  1'b0};
        vecs[8] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,         1'b1, 5'd9, 32'h00000099,  1'b1};
        vecs[9] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 32'h0,         1'b1};

        // Reset holds outputs low even with a pipeline write presented.
        idle();
        RESET = 1'b0;
        RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'hAAAA0001;
        #12;
        check("rst_we", {31'd0, RfWE}, 32'd0);
        check("rst_stall", {31'd0, StallReq}, 32'd0);
        check("rst_mask", PendingMask, 32'd0);
        idle();
        #1 RESET = 1'b1;
        cyc();
        check("rst_ready", {31'd0, LongReady}, 32'd1);
        monEn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            RegWriteW = vecs[i].rw; RdW = vecs[i].rd; ResultW = vecs[i].res;
            LongValid = vecs[i].lv; LongRd = vecs[i].lrd; LongData = vecs[i].ldata;
            @(negedge CLK);
            check($sformatf("vec%0d_we", i), {31'd0, RfWE}, {31'd0, vecs[i].we});
            check($sformatf("vec%0d_rd", i), {27'd0, RfRd}, {27'd0, vecs[i].erd});
            check($sformatf("vec%0d_wd", i), RfWD, vecs[i].ewd);
            check($sformatf("vec%0d_ready", i), {31'd0, LongReady}, {31'd0, vecs[i].ready});
            cyc();
        end
        idle();

        // Pending scoreboard: set at issue edge, clear at pop edge; x0 never tracked.
        IssueLong = 1'b1; IssueRd = 5'd9;
        cyc();
        IssueLong = 1'b0; IssueRd = '0;
        check("pend_set", PendingMask, 32'h0000_0200);
        cyc(); cyc();
        check("pend_hold", PendingMask, 32'h0000_0200);
        RegWriteW = 1'b1; RdW = 5'd2; ResultW = 32'h2;
        LongValid = 1'b1; LongRd = 5'd9; LongData = 32'h9999;
        cyc();
        idle();
        check("pend_before_pop", PendingMask, 32'h0000_0200);
        cyc();
        check("pend_cleared", PendingMask, 32'h0);
        IssueLong = 1'b1; IssueRd = 5'd0;
        cyc();
        idle();
        check("pend_x0", PendingMask, 32'h0);

        // Full queue back-pressure, then in-order drain.
        RegWriteW = 1'b1; RdW = 5'd1; ResultW = 32'h1;
        LongValid = 1'b1; LongRd = 5'd3; LongData = 32'h3;
        cyc();
        LongRd = 5'd4; LongData = 32'h4;
        cyc();
        LongRd = 5'd5; LongData = 32'h5;
        @(negedge CLK);
        check("bp_full_ready", {31'd0, LongReady}, 32'd0);
        cyc();
        RegWriteW = 1'b0; RdW = '0;
        @(negedge CLK);
        check("bp_pop_ready", {31'd0, LongReady}, 32'd0);
        check("bp_first_rd", {27'd0, RfRd}, 32'd3);
        cyc();
        @(negedge CLK);
        check("bp_second_rd", {27'd0, RfRd}, 32'd4);
        check("bp_ready_back", {31'd0, LongReady}, 32'd1);
        cyc();
        LongValid = 1'b0;
        @(negedge CLK);
        check("bp_third_rd", {27'd0, RfRd}, 32'd5);
        cyc();
        idle();

        // Starvation: StallReq after exactly 8 blocked cycles, drops once the head is written.
        RegWriteW = 1'b1; RdW = 5'd1; ResultW = 32'h1;
        LongValid = 1'b1; LongRd = 5'd11; LongData = 32'hBB;
        cyc();
        LongValid = 1'b0; LongRd = '0;
        repeat (7) cyc();
        check("starve_7", {31'd0, StallReq}, 32'd0);
        cyc();
        check("starve_8", {31'd0, StallReq}, 32'd1);
        RegWriteW = 1'b0; RdW = '0;
        @(negedge CLK);
        check("starve_head_rd", {27'd0, RfRd}, 32'd11);
        check("starve_hold", {31'd0, StallReq}, 32'd1);
        cyc();
        check("starve_clear", {31'd0, StallReq}, 32'd0);
        idle();

        // Asynchronous reset in the middle of operation discards everything.
        IssueLong = 1'b1; IssueRd = 5'd6;
        cyc();
        IssueRd = 5'd7;
        cyc();
        IssueLong = 1'b0; IssueRd = '0;
        check("mid_mask", PendingMask, 32'h0000_00C0);
        RegWriteW = 1'b1; RdW = 5'd1; ResultW = 32'h1;
        LongValid = 1'b1; LongRd = 5'd6; LongData = 32'h66;
        cyc();
        LongRd = 5'd7; LongData = 32'h77;
        cyc();
        LongValid = 1'b0; LongRd = '0;
        #1 RESET = 1'b0;
        #1;
        check("mid_rst_we", {31'd0, RfWE}, 32'd0);
        check("mid_rst_stall", {31'd0, StallReq}, 32'd0);
        check("mid_rst_mask", PendingMask, 32'h0);
        sbQ.delete();
        idle();
        @(negedge CLK);
        RESET = 1'b1;
        cyc();
        check("mid_rel_ready", {31'd0, LongReady}, 32'd1);
        check("mid_rel_we", {31'd0, RfWE}, 32'd0);
        cyc(); cyc();

        // Same-cycle issue and long result for one register.
        LongValid = 1'b1; LongRd = 5'd12; LongData = 32'hC;
        IssueLong = 1'b1; IssueRd = 5'd12;
`ifdef WBARB_BYPASS_EN
        @(negedge CLK);
        check("sc_we", {31'd0, RfWE}, 32'd1);
        check("sc_rd", {27'd0, RfRd}, 32'd12);
        cyc();
        idle();
        check("sc_mask", {31'd0, PendingMask[12]}, 32'd1);
`else
        @(negedge CLK);
        check("sc_we_now", {31'd0, RfWE}, 32'd0);
        cyc();
        idle();
        @(negedge CLK);
        check("sc_we_next", {31'd0, RfWE}, 32'd1);
        check("sc_rd_next", {27'd0, RfRd}, 32'd12);
        cyc();
        check("sc_mask", {31'd0, PendingMask[12]}, 32'd0);
`endif
        cyc(); cyc();
        check("sb_drained", sbQ.size(), 32'd0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
